stream_unpacker: RTL and testbench
==================================

STREAM_UNPACKER -- requirements
Module: stream_unpacker

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 8, number of valid compression patterns.
REQ-002 SHALL derive localparam LEN_ENCODE = $clog2(NUM_PATTERNS), the pattern-ID field width (3 at default).
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port word_i  in  64  compressed stream word, MSB = earliest bit.
REQ-006 SHALL have port en_i  in  1  word_i valid.
REQ-007 SHALL have port ready_o  out  1  block can accept word_i this cycle.
REQ-008 SHALL have port flush_i  in  1  discard all buffered bits (end of compressed block).
REQ-009 SHALL have port data_o  out  256+LEN_ENCODE  {pattern ID, 256-bit payload}, feeds DECONCAT data_i.
REQ-010 SHALL have port en_o  out  1  data_o valid, one-cycle pulse; downstream always accepts.
REQ-011 SHALL have port err_o  out  1  sticky invalid-pattern flag.

Function
REQ-012 SHALL hold a 384-bit bit buffer with fill counter (0..384); a word is accepted on an edge where en_i && ready_o and is appended after the newest buffered bit.
REQ-013 SHALL drive ready_o = (fill <= 320) from registered state only; en_i while ready_o=0 SHALL be ignored.
REQ-014 SHALL parse records as: LEN_ENCODE-bit pattern ID, then 8-bit field N, then L = N+1 payload bits (1..256), all in stream order, with no padding between records.
REQ-015 SHALL implement FSM states HDR and PAY; HDR: if fill >= LEN_ENCODE+8, latch pattern and L, consume header bits, go to PAY; else stay.
REQ-016 PAY: if fill >= L, consume L bits, register data_o = {pattern, payload} with payload right-aligned (last stream bit = bit 0, bits 255:L zero), pulse en_o next cycle, go to HDR; else stay.
REQ-017 SHALL update fill as fill - consumed + (64 if accepted) in one edge; acceptance and consumption in the same cycle are legal.
REQ-018 Latency: for a record wholly contained in a word accepted at edge k, en_o SHALL be high in the cycle after edge k+2; sustained throughput is at most one record per 2 cycles.
REQ-019 SHALL keep data_o unchanged between en_o pulses.
REQ-020 flush_i SHALL set fill to 0 and state to HDR; no en_o for a partial record; if en_i is accepted on the same edge, fill becomes 64 with that word only.
REQ-021 flush_i has priority over header/payload extraction on the same edge.
REQ-022 fill SHALL never exceed 384; ready_o guarantees this.

Reset
REQ-023 On rst=1 at an edge: state HDR, fill 0, buffer 0, data_o 0, en_o 0, err_o 0; ready_o reads 1 in the following cycle.
REQ-024 rst mid-record SHALL drop the record and all buffered bits; rst has priority over flush_i and en_i.

Configuration
REQ-025 Macro UNPACK_PATTERN_CHECK_EN defined: a parsed pattern ID >= NUM_PATTERNS SHALL set err_o (sticky until rst), its payload SHALL still be consumed, and en_o SHALL NOT pulse for it.
REQ-026 Macro undefined: no check; err_o tied 0; every record is emitted unchanged.

Verification
REQ-027 rst high 2 cycles, en_i=0 -> en_o=0, data_o=0, err_o=0, ready_o=1.
REQ-028 Word {3'd5, 8'd15, 16'hBEEF, 37'd0} accepted at edge k -> en_o high after edge k+2, data_o = {3'd5, 240'd0, 16'hBEEF}, exactly one pulse.
REQ-029 Record pattern 2, N=255, payload all ones, across 5 consecutive words -> single en_o after the fifth word, data_o = {3'd2, {256{1'b1}}}; no earlier en_o.
REQ-030 Continuous en_i=1 with headers N=255 -> ready_o drops whenever fill > 320, words offered during ready_o=0 not consumed, output records bit-exact vs. golden model.
REQ-031 NUM_PATTERNS=6, record with pattern 7 followed by a pattern 1 record -> with macro: err_o=1, only the pattern-1 record emitted; without: both emitted, err_o=0.
REQ-032 flush_i in PAY with 40 of 200 payload bits buffered -> no en_o, state HDR, fill 0; next header word then parses correctly.

Source files
------------

// File: rtl/stream_unpacker_if.sv
// Stream unpacker port bundle: compressed word input with backpressure,
// flush control, and the decoded {pattern ID, payload} record output.
interface stream_unpacker_if #(
    parameter int NUM_PATTERNS = 8
);
    localparam int LEN_ENCODE = $clog2(NUM_PATTERNS);

    logic [63:0]               word_i;
    logic                      en_i;
    logic                      ready_o;
    logic                      flush_i;
    logic [256+LEN_ENCODE-1:0] data_o;
    logic                      en_o;
    logic                      err_o;

    modport master (
        output word_i, en_i, flush_i,
        input  ready_o, data_o, en_o, err_o
    );

    modport slave (
        input  word_i, en_i, flush_i,
        output ready_o, data_o, en_o, err_o
    );
endinterface

// File: rtl/stream_unpacker.sv
// Stream unpacker: splits a 64-bit compressed word stream into records of
// {pattern ID, N, N+1 payload bits} and emits each as a right-aligned
// 256-bit payload tagged with its pattern ID.
// Optional feature: define UNPACK_PATTERN_CHECK_EN to flag (sticky err_o)
// and suppress records whose pattern ID is >= NUM_PATTERNS.
//
// state | meaning
// ------+-----------------------------------------------------------
// HDR   | waiting for LEN_ENCODE+8 header bits, then latches ID and L
// PAY   | waiting for L payload bits, then emits the record
module stream_unpacker #(
    parameter int NUM_PATTERNS = 8
) (
    input logic               clk,
    input logic               rst,
    stream_unpacker_if.slave  bus
);
    localparam int          LEN_ENCODE = $clog2(NUM_PATTERNS);
    localparam int          BUF_W      = 384;
    localparam logic [8:0]  HDR_BITS   = 9'(LEN_ENCODE + 8);
    localparam logic [8:0]  READY_MAX  = 9'd320;

    typedef enum logic {HDR, PAY} state_t;

    state_t                    state_q, state_d;
    logic [BUF_W-1:0]          bits_q;
    logic [8:0]                fill_q;
    logic [LEN_ENCODE-1:0]     pat_q;
    logic [8:0]                len_q;
    logic [256+LEN_ENCODE-1:0] data_q;
    logic                      en_q;

    logic                      accept;
    logic                      hdr_take;
    logic                      pay_take;
    logic                      emit_ok;
    logic [8:0]                consume;
    logic [8:0]                fill_kept;
    logic [BUF_W-1:0]          bits_kept;
    logic [BUF_W-1:0]          word_ins;
    logic [LEN_ENCODE-1:0]     hdr_pat;
    logic [7:0]                hdr_n;
    logic [255:0]              payload;

    // Oldest buffered bit sits at bits_q[383]; bits below fill are always zero.
    assign bus.ready_o = (fill_q <= READY_MAX);
    assign accept      = bus.en_i && bus.ready_o;
    assign hdr_pat     = bits_q[BUF_W-1 -: LEN_ENCODE];
    assign hdr_n       = bits_q[BUF_W-1-LEN_ENCODE -: 8];
    assign payload     = bits_q[BUF_W-1 -: 256] >> (9'd256 - len_q);
    assign fill_kept   = fill_q - consume;
    assign bits_kept   = bits_q << consume;
    assign word_ins    = {bus.word_i, 320'd0} >> fill_kept;
    assign bus.data_o  = data_q;
    assign bus.en_o    = en_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HDR;
        else     state_q <= state_d;
    end

    // Next state and bit consumption; flush overrides any extraction.
    always_comb begin
        state_d  = state_q;
        consume  = 9'd0;
        hdr_take = 1'b0;
        pay_take = 1'b0;
        if (bus.flush_i) begin
            state_d = HDR;
        end else begin
            case (state_q)
                HDR: begin
                    if (fill_q >= HDR_BITS) begin
                        consume  = HDR_BITS;
                        hdr_take = 1'b1;
                        state_d  = PAY;
                    end
                end
                PAY: begin
                    if (fill_q >= len_q) begin
                        consume  = len_q;
                        pay_take = 1'b1;
                        state_d  = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Bit buffer: shift out consumed bits and append an accepted word behind the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
            fill_q <= 9'd0;
        end else if (bus.flush_i) begin
            bits_q <= accept ? {bus.word_i, 320'd0} : '0;
            fill_q <= accept ? 9'd64 : 9'd0;
        end else begin
            bits_q <= bits_kept | (accept ? word_ins : '0);
            fill_q <= fill_kept + (accept ? 9'd64 : 9'd0);
        end
    end

    // Header latch and record output register; data_o holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= 9'd0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (hdr_take) begin
                pat_q <= hdr_pat;
                len_q <= {1'b0, hdr_n} + 9'd1;
            end
            if (pay_take && emit_ok) begin
                data_q <= {pat_q, payload};
                en_q   <= 1'b1;
            end
        end
    end

`ifdef UNPACK_PATTERN_CHECK_EN
    localparam logic [LEN_ENCODE:0] NUM_PAT_W = (LEN_ENCODE+1)'(NUM_PATTERNS);

    logic bad_q;
    logic err_q;

    // Flag out-of-range IDs at header time; the payload is still consumed later.
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else if (hdr_take) begin
            bad_q <= ({1'b0, hdr_pat} >= NUM_PAT_W);
            if ({1'b0, hdr_pat} >= NUM_PAT_W) err_q <= 1'b1;
        end
    end

    assign emit_ok    = !bad_q;
    assign bus.err_o  = err_q;
`else
    assign emit_ok    = 1'b1;
    assign bus.err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: reset, single-word record, multi-word
// record, flush handling, backpressured continuous stream, pattern check.
`timescale 1ns/1ps
module tb_stream_unpacker;
    localparam int NUM_PATTERNS = 6;
    localparam int DW           = 256 + $clog2(NUM_PATTERNS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stream_unpacker_if #(.NUM_PATTERNS(NUM_PATTERNS)) bus();

    stream_unpacker #(.NUM_PATTERNS(NUM_PATTERNS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit              sbits [4096];
    int              slen;
    logic [DW-1:0]   exp_rec [32];
    int              nexp;
    int              nout;
    int              widx;
    int              nwords;
    int              pulses;
    logic            rdy;
    logic            saw_stall;
    logic [319:0]    s29;
    logic [2:0]      p;
    logic [7:0]      n;
    logic [255:0]    pay;
    int              len;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [255:0] v, input int nb);
        for (int b = nb - 1; b >= 0; b--) begin
            sbits[slen] = v[b];
            slen++;
        end
    endtask

    function automatic logic [63:0] mkword(input int w);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[63-j] = sbits[w*64 + j];
        return r;
    endfunction

    task automatic send(input logic [63:0] w);
        bus.en_i   = 1'b1;
        bus.word_i = w;
        step();
        bus.en_i   = 1'b0;
    endtask

    task automatic add_rec(input logic [7:0] nn);
        p   = 3'($urandom_range(0, 5));
        len = int'(nn) + 1;
        pay = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        pay = pay & ((256'd1 << len) - 256'd1);
        exp_rec[nexp] = {p, pay};
        nexp++;
        push({253'd0, p}, 3);
        push({248'd0, nn}, 8);
        push(pay, len);
    endtask

    initial begin
        bus.en_i    = 1'b0;
        bus.flush_i = 1'b0;
        bus.word_i  = '0;

        // reset for two cycles
        rst = 1'b1;
        step();
        step();
        chk1("rst_en_o", bus.en_o, 1'b0);
        chk("rst_data_o", bus.data_o, '0);
        chk1("rst_err_o", bus.err_o, 1'b0);
        chk1("rst_ready_o", bus.ready_o, 1'b1);
        rst = 1'b0;

        // single-word record, exactly one pulse (trailing zeros flushed)
        send({3'd5, 8'd15, 16'hBEEF, 37'd0});
        chk1("w1_en_k", bus.en_o, 1'b0);
        step();
        chk1("w1_en_k1", bus.en_o, 1'b0);
        step();
        chk1("w1_en_k2", bus.en_o, 1'b1);
        chk("w1_data", bus.data_o, {3'd5, 240'd0, 16'hBEEF});
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.en_o) pulses++;
            step();
        end
        chk_int("w1_extra_pulses", pulses, 0);
        chk("w1_data_held", bus.data_o, {3'd5, 240'd0, 16'hBEEF});

        // 256-bit all-ones record spread over five words
        s29 = {3'd2, 8'd255, {256{1'b1}}, 3'd1, 8'd255, 42'd0};
        for (int i = 0; i < 5; i++) begin
            send(s29[319 - 64*i -: 64]);
            chk1("long_no_early_en", bus.en_o, 1'b0);
        end
        step();
        chk1("long_en", bus.en_o, 1'b1);
        chk("long_data", bus.data_o, {3'd2, {256{1'b1}}});
        step();
        chk1("long_single_pulse", bus.en_o, 1'b0);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk_int("long_flush_fill", int'(dut.fill_q), 0);

        // flush in PAY with 40 of 200 payload bits buffered
        send({3'd1, 8'd1, 2'b10, 3'd3, 8'd199, 40'hAB_CDEF_0123});
        step();
        step();
        chk1("pf_first_en", bus.en_o, 1'b1);
        chk("pf_first_data", bus.data_o, {3'd1, 254'd0, 2'b10});
        step();
        chk_int("pf_fill_before", int'(dut.fill_q), 40);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk_int("pf_fill_after", int'(dut.fill_q), 0);
        chk1("pf_ready", bus.ready_o, 1'b1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.en_o) pulses++;
            step();
        end
        chk_int("pf_no_partial", pulses, 0);
        send({3'd4, 8'd7, 8'hA5, 3'd0, 8'd255, 34'd0});
        step();
        step();
        chk1("pf_next_en", bus.en_o, 1'b1);
        chk("pf_next_data", bus.data_o, {3'd4, 248'd0, 8'hA5});

        // flush and a new word on the same edge: only the new word survives
        bus.flush_i = 1'b1;
        send({3'd2, 8'd3, 4'hC, 3'd0, 8'd255, 38'd0});
        bus.flush_i = 1'b0;
        chk_int("fw_fill", int'(dut.fill_q), 64);
        step();
        chk1("fw_en_k1", bus.en_o, 1'b0);
        step();
        chk1("fw_en_k2", bus.en_o, 1'b1);
        chk("fw_data", bus.data_o, {3'd2, 252'd0, 4'hC});
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;

        // continuous stream with backpressure against a golden record list
        slen = 0;
        nexp = 0;
        for (int r = 0; r < 4; r++)  add_rec(8'd255);
        for (int r = 0; r < 14; r++) add_rec(8'd3);
        for (int r = 0; r < 4; r++)  add_rec(8'd255);
        push({253'd0, 3'd0}, 3);
        push({248'd0, 8'd255}, 8);
        nwords = (slen + 63) / 64;
        widx = 0;
        nout = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 3000 && !(widx == nwords && nout == nexp); cyc++) begin
            if (widx < nwords) begin
                bus.en_i   = 1'b1;
                bus.word_i = mkword(widx);
            end else begin
                bus.en_i = 1'b0;
            end
            rdy = bus.ready_o;
            chk1("cs_ready_vs_fill", rdy, dut.fill_q <= 9'd320);
            step();
            if (bus.en_i && rdy) widx++;
            if (!rdy) saw_stall = 1'b1;
            if (bus.en_o) begin
                if (nout < nexp) chk("cs_record", bus.data_o, exp_rec[nout]);
                nout++;
            end
        end
        bus.en_i = 1'b0;
        chk_int("cs_words_taken", widx, nwords);
        chk_int("cs_record_count", nout, nexp);
        chk1("cs_saw_stall", saw_stall, 1'b1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;

        // out-of-range pattern 7 followed by pattern 1
        send({3'd7, 8'd3, 4'hF, 3'd1, 8'd3, 4'h9, 3'd0, 8'd255, 23'd0});
        step();
        step();
`ifdef UNPACK_PATTERN_CHECK_EN
        chk1("pc_bad_no_en", bus.en_o, 1'b0);
        chk1("pc_err_set", bus.err_o, 1'b1);
`else
        chk1("pc_bad_en", bus.en_o, 1'b1);
        chk("pc_bad_data", bus.data_o, {3'd7, 252'd0, 4'hF});
        chk1("pc_err_clear", bus.err_o, 1'b0);
`endif
        step();
        chk1("pc_gap", bus.en_o, 1'b0);
        step();
        chk1("pc_good_en", bus.en_o, 1'b1);
        chk("pc_good_data", bus.data_o, {3'd1, 252'd0, 4'h9});
`ifdef UNPACK_PATTERN_CHECK_EN
        chk1("pc_err_sticky", bus.err_o, 1'b1);
`else
        chk1("pc_err_still_0", bus.err_o, 1'b0);
`endif

        // reset mid-record beats flush and en_i
        rst         = 1'b1;
        bus.flush_i = 1'b1;
        bus.en_i    = 1'b1;
        bus.word_i  = {3'd5, 8'd15, 16'hBEEF, 37'd0};
        step();
        chk_int("rr_fill", int'(dut.fill_q), 0);
        chk1("rr_err", bus.err_o, 1'b0);
        chk("rr_data", bus.data_o, '0);
        step();
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        bus.en_i    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.en_o) pulses++;
        end
        chk_int("rr_no_pulse", pulses, 0);
        chk1("rr_ready", bus.ready_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
